// File: rtl/mac_pkg.sv
// Shared definitions for the MAC drain blocks: widths, FSM encoding and
// the round/shift/saturate quantizer applied to the PE's wide product.
package mac_pkg;

   localparam int W    = 16;
   localparam int OW   = 16;
   localparam int SH_W = 5;
   localparam int XW   = 2*W + 1;

   typedef enum logic {
      ACCUM   = 1'b0,
      CAPTURE = 1'b1
   } state_t;

   typedef struct packed {
      logic          sat;
      logic [OW-1:0] data;
   } quant_t;

   // One guard bit keeps the rounding add from overflowing; the result is
   // then clamped to the signed OW-bit range.
   function automatic quant_t quantize(input logic [2*W-1:0] product,
                                       input logic [SH_W-1:0] shift);
      logic signed [XW-1:0] ext;
      logic signed [XW-1:0] rnd;
      logic signed [XW-1:0] shifted;
      logic signed [XW-1:0] max_v;
      logic signed [XW-1:0] min_v;
      quant_t               q;
      max_v = XW'(2**(OW-1) - 1);
      min_v = ~max_v;
      ext   = $signed({product[2*W-1], product});
      rnd   = '0;
      if (shift != '0) begin
         rnd = XW'(1) << (shift - SH_W'(1));
      end
      shifted = (ext + rnd) >>> shift;
      q.sat   = 1'b0;
      q.data  = shifted[OW-1:0];
      if (shifted > max_v) begin
         q.sat  = 1'b1;
         q.data = max_v[OW-1:0];
      end else if (shifted < min_v) begin
         q.sat  = 1'b1;
         q.data = min_v[OW-1:0];
      end
      return q;
   endfunction

endpackage

// File: rtl/mac_result_fifo.sv
// Small result FIFO; the head entry is presented straight from storage.
module mac_result_fifo #(
   parameter int DEPTH = 4,
   parameter int OW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [OW-1:0] push_data,
   input  logic          pop,
   output logic          full,
   output logic          empty,
   output logic [OW-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [OW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head    = mem[rd_ptr[AW-1:0]];

   // Storage and pointer update; the extra pointer bit separates full from empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mac_drain_quant.sv
// Drains the MAC PE: counts a window of beats, captures the accumulated
// product, clears the PE and queues the quantized result.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ACCUM   | accepting beats; beats_left counts down the open window
//   CAPTURE | product holds the window sum; push result, clear the PE
module mac_drain_quant #(
   parameter int W     = 16,
   parameter int OW    = 16,
   parameter int DEPTH = 4,
   parameter int LEN_W = 8,
   parameter int SH_W  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LEN_W-1:0]      cfg_len,
   input  logic [SH_W-1:0]       cfg_shift,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic signed [2*W-1:0] product,
   output logic                  pe_clear,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [OW-1:0]         out_data,
   output logic                  sat_flag
);

   import mac_pkg::*;

   state_t           state;
   state_t           state_nxt;
   logic [LEN_W-1:0] beats_left;
   logic [LEN_W-1:0] beats_left_nxt;
   logic [LEN_W-1:0] len_eff;
   logic [SH_W-1:0]  shift_q;
   logic             win_start;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_empty;
   quant_t           q;

   // A zero length would never close a window, so it runs as one beat.
   assign len_eff   = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
   assign q         = quantize(product, shift_q);
   assign out_valid = !fifo_empty;

   // State, window down-counter, latched shift and sticky saturation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ACCUM;
         beats_left <= '0;
         shift_q    <= '0;
         sat_flag   <= 1'b0;
      end else begin
         state      <= state_nxt;
         beats_left <= beats_left_nxt;
         if (win_start) begin
            shift_q <= cfg_shift;
         end
         if (fifo_push && q.sat) begin
            sat_flag <= 1'b1;
         end
      end
   end

   // Next-state, beat acceptance and PE clear; beats_left==1 is the last beat.
   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      in_ready       = 1'b0;
      pe_clear       = rst;
      fifo_push      = 1'b0;
      win_start      = 1'b0;
      case (state)
         ACCUM: begin
            in_ready = !rst && !fifo_full;
            if (in_valid && !rst && !fifo_full) begin
               if (beats_left == '0) begin
                  win_start = 1'b1;
                  if (len_eff == LEN_W'(1)) begin
                     state_nxt = CAPTURE;
                  end else begin
                     beats_left_nxt = len_eff - LEN_W'(1);
                  end
               end else if (beats_left == LEN_W'(1)) begin
                  state_nxt      = CAPTURE;
                  beats_left_nxt = '0;
               end else begin
                  beats_left_nxt = beats_left - LEN_W'(1);
               end
            end
         end
         CAPTURE: begin
            pe_clear  = 1'b1;
            fifo_push = 1'b1;
            state_nxt = ACCUM;
         end
      endcase
   end

   mac_result_fifo #(
      .DEPTH (DEPTH),
      .OW    (OW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (q.data),
      .pop       (out_valid && out_ready),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (out_data)
   );

endmodule

// File: tb/tb_mac_drain_quant.sv
// Bench for mac_drain_quant with a behavioural PE and a window-level
// reference model that predicts every result leaving the FIFO.
module tb_mac_drain_quant;

   localparam int W     = 16;
   localparam int OW    = 16;
   localparam int DEPTH = 4;
   localparam int LEN_W = 8;
   localparam int SH_W  = 5;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [LEN_W-1:0]      cfg_len = '0;
   logic [SH_W-1:0]       cfg_shift = '0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic signed [2*W-1:0] product;
   logic                  pe_clear;
   logic                  out_valid;
   logic                  out_ready = 1'b0;
   logic [OW-1:0]         out_data;
   logic                  sat_flag;
   logic signed [W-1:0]   a = '0;
   logic signed [W-1:0]   b = '0;

   int checks = 0;
   int errors = 0;

   longint exp_q[$];
   longint popped[$];
   int     m_cnt = 0;
   int     m_len = 1;
   int     m_sh  = 0;
   int     m_sum = 0;
   bit     m_sat = 1'b0;
   int     beats_acc = 0;
   bit     done = 1'b0;

   typedef struct {
      int len;
      int sh;
      int a;
      int b;
      int exp_data;
      bit exp_sat;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   mac_drain_quant #(
      .W(W), .OW(OW), .DEPTH(DEPTH), .LEN_W(LEN_W), .SH_W(SH_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_len   (cfg_len),
      .cfg_shift (cfg_shift),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .product   (product),
      .pe_clear  (pe_clear),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_flag  (sat_flag)
   );

   // Behavioural PE: registered multiply-accumulate with synchronous clear.
   always @(posedge clk) begin
      if (pe_clear) product <= '0;
      else if (in_valid && in_ready) product <= product + a * b;
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=event", nm);
   endtask

   function automatic longint ref_q(input int s, input int sh, output bit sat);
      longint v;
      longint hi;
      longint lo;
      hi  = (longint'(1) << (OW - 1)) - 1;
      lo  = -(longint'(1) << (OW - 1));
      v   = s;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v   = v >>> sh;
      sat = 1'b0;
      if (v > hi) begin v = hi; sat = 1'b1; end
      if (v < lo) begin v = lo; sat = 1'b1; end
      return v;
   endfunction

   // Reference model and scoreboard, sampled mid-cycle when everything is stable.
   always @(negedge clk) begin
      bit s;
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         m_sum = 0;
         m_sat = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            popped.push_back(longint'($signed(out_data)));
            if (exp_q.size() == 0) begin
               chk("pop_unexpected", 1, 0);
            end else begin
               chk("scoreboard_data", $signed(out_data), exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) begin
            beats_acc++;
            if (m_cnt == 0) begin
               m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
               m_sh  = int'(cfg_shift);
               m_sum = 0;
            end
            m_sum = m_sum + int'(a) * int'(b);
            m_cnt++;
            if (m_cnt == m_len) begin
               exp_q.push_back(ref_q(m_sum, m_sh, s));
               m_sat = m_sat | s;
               m_cnt = 0;
            end
         end
      end
   end

   task automatic beat(input int av, input int bv);
      bit acc;
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      a = W'(av);
      b = W'(bv);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      a = '0;
      b = '0;
      if (!ok) fail("beat_accept");
   endtask

   task automatic run_window(input int len, input int sh, input int av, input int bv);
      int nb;
      cfg_len   = LEN_W'(len);
      cfg_shift = SH_W'(sh);
      nb = (len == 0) ? 1 : len;
      for (int i = 0; i < nb; i++) beat(av, bv);
   endtask

   task automatic get_result(input string nm, output longint d, output bit ok);
      ok = 1'b0;
      d  = 0;
      for (int t = 0; t < 64; t++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         fail(nm);
      end else begin
         d = longint'($signed(out_data));
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      longint d;
      bit     ok;
      int     exp_vals[5];

      vecs.push_back('{1, 2, 61, 1, 15, 1'b0});
      vecs.push_back('{1, 3, -100, 1, -12, 1'b0});
      vecs.push_back('{1, 0, 32767, 32767, 32767, 1'b1});
      vecs.push_back('{1, 0, 2, 3, 6, 1'b1});
      vecs.push_back('{0, 0, 7, 7, 49, 1'b1});
      vecs.push_back('{2, 1, -32768, 32767, -32768, 1'b1});
      vecs.push_back('{3, 16, 1000, 1000, 46, 1'b1});
      vecs.push_back('{1, 1, -3, 1, -1, 1'b1});
      vecs.push_back('{1, 31, 1, 1, 0, 1'b1});
      vecs.push_back('{1, 1, 5, 1, 3, 1'b1});

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_pe_clear", pe_clear, 1);
      chk("rst_in_ready", in_ready, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_in_ready", in_ready, 1);
      chk("idle_pe_clear", pe_clear, 0);

      // four-beat window and capture timing
      run_window(4, 0, 3, 5);
      chk("cap_pe_clear", pe_clear, 1);
      chk("cap_in_ready", in_ready, 0);
      chk("cap_out_valid", out_valid, 0);
      chk("cap_product", product, 60);
      @(posedge clk);
      #1;
      chk("post_pe_clear", pe_clear, 0);
      chk("post_out_valid", out_valid, 1);
      chk("post_out_data", $signed(out_data), 60);
      chk("post_in_ready", in_ready, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("post_pop_empty", out_valid, 0);

      // table of single-window vectors
      for (int i = 0; i < vecs.size(); i++) begin
         run_window(vecs[i].len, vecs[i].sh, vecs[i].a, vecs[i].b);
         get_result($sformatf("vec%0d_data", i), d, ok);
         if (ok) chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
         chk($sformatf("vec%0d_sat", i), sat_flag, vecs[i].exp_sat);
      end

      // zero length: every beat is its own window
      cfg_len = '0;
      cfg_shift = '0;
      beat(1, 1);
      beat(2, 1);
      beat(3, 1);
      for (int i = 1; i <= 3; i++) begin
         get_result("len0_data", d, ok);
         if (ok) chk("len0_data", d, i);
      end

      // idle gaps inside a window
      cfg_len = LEN_W'(3);
      beat(2, 3);
      @(posedge clk); #1;
      beat(4, 5);
      @(posedge clk); #1;
      beat(6, 7);
      get_result("gap_data", d, ok);
      if (ok) chk("gap_data", d, 68);

      // back-pressure: five windows against a stalled output
      popped.delete();
      beats_acc = 0;
      cfg_len = LEN_W'(2);
      cfg_shift = '0;
      fork
         begin
            for (int w = 0; w < 5; w++) begin
               beat(w + 1, 1);
               beat(w + 1, 1);
            end
         end
         begin
            repeat (30) @(posedge clk);
            #1;
            chk("full_in_ready", in_ready, 0);
            chk("full_out_valid", out_valid, 1);
            chk("full_beats_held", beats_acc, 8);
            out_ready = 1'b1;
         end
      join
      repeat (6) @(posedge clk);
      #1;
      out_ready = 1'b0;
      exp_vals = '{2, 4, 6, 8, 10};
      chk("full_pop_count", popped.size(), 5);
      for (int i = 0; i < 5 && i < popped.size(); i++) begin
         chk($sformatf("full_order%0d", i), popped[i], exp_vals[i]);
      end

      // reset mid-window with queued entries
      cfg_len = LEN_W'(1);
      beat(11, 1);
      beat(22, 1);
      cfg_len = LEN_W'(4);
      beat(5, 5);
      beat(5, 5);
      chk("pre_rst_out_valid", out_valid, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_pe_clear", pe_clear, 1);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_sat_flag", sat_flag, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      run_window(4, 0, 1, 2);
      get_result("fresh_data", d, ok);
      if (ok) chk("fresh_data", d, 8);
      repeat (2) @(posedge clk);
      #1;
      chk("fresh_only_one", out_valid, 0);

      // randomized traffic against the reference model
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 120; i++) begin
               cfg_len   = LEN_W'($urandom_range(0, 5));
               cfg_shift = SH_W'($urandom_range(0, 31));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               beat(int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 1) == 1);
            end
         end
      join
      out_ready = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      chk("rand_drained_model", exp_q.size(), 0);
      chk("rand_drained_dut", out_valid, 0);
      chk("rand_sat_flag", sat_flag, m_sat);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mac_drain_quant.md
Name: mac_drain_quant

Overview:
- Downstream consumer of the 16-bit Booth/Wallace MAC PE.
- Counts operand beats fed to the PE over a dot-product window of cfg_len beats, then captures the PE's accumulated product one cycle after the last beat.
- Pulses the PE clear so the next window starts from zero.
- Rounds, shifts and saturates the 2W-bit result to OW bits, and buffers it in a small FIFO with a valid/ready output handshake.

Parameters:
- W, 16, PE operand width; the PE product is 2W bits.
- OW, 16, width of the quantized output.
- DEPTH, 4, number of result FIFO entries (power of two, at least 2).
- LEN_W, 8, width of cfg_len.
- SH_W, 5, width of cfg_shift (must cover 0..2W-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_len  in  LEN_W  beats per window; 0 is treated as 1; sampled at window start.
- cfg_shift  in  SH_W  arithmetic right-shift amount; sampled at window start.
- in_valid  in  1  upstream presents a valid operand pair to the PE this cycle.
- in_ready  out  1  block accepts a beat; upstream must drive PE operands to 0 whenever in_valid & in_ready is low.
- product  in  2W  PE registered product (signed).
- pe_clear  out  1  drives the PE's synchronous rst; clears its accumulator.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  OW  quantized result (signed), FIFO head.
- sat_flag  out  1  sticky; set when any result saturated; cleared only by rst.

Behaviour:
- Reset (async assert, sync release): state=ACCUM, beat count=0, FIFO empty, out_valid=0, out_data=0, sat_flag=0. pe_clear=1 while rst is high. in_ready=0 while rst is high.
- in_ready = (state==ACCUM) && !fifo_full. It is combinational from registered state only; no dependence on in_valid.
- A beat is accepted when in_valid && in_ready. On the first beat of a window (count==0), latch len_q = max(cfg_len,1) and shift_q = cfg_shift.
- ACCUM: on each accepted beat, count++. When the accepted beat is beat len_q (count==len_q-1), go to CAPTURE and set count=0.
- CAPTURE (exactly 1 cycle):
  - PE latency is 1, so product now holds the full window sum.
  - in_ready=0 and pe_clear=1. The PE clears on the same edge that the block samples product.
  - Push the quantized value into the FIFO. Space is guaranteed: in_ready was high for the last beat and no push occurs in between.
  - Return to ACCUM.
- pe_clear=0 in ACCUM.
- Quantize:
  - Extend product to 2W+1 bits.
  - If shift_q>0, add 2^(shift_q-1) (round half up).
  - Arithmetic right-shift by shift_q.
  - If the result > 2^(OW-1)-1 or < -2^(OW-1), clamp to the bound and set sat_flag.
  - Combinational; registered only by the FIFO write.
- FIFO:
  - Write-before-read storage. Simultaneous push and pop is allowed when full or empty.
  - out_data is the head entry (registered storage). It holds its value while out_valid && !out_ready.
  - A pop occurs when out_valid && out_ready; out_valid drops the cycle after the last entry pops.
  - Results emerge in window order.
- No result is lost: input backpressure (in_ready=0 when full) is the only overflow protection.
- Idle gaps (in_valid=0) inside a window are allowed: count holds, and the PE adds 0 because operands are zero.
- Reset mid-window: window discarded, FIFO flushed, PE cleared via pe_clear.
- cfg changes mid-window have no effect until the next window start.

Decomposition:
- Shared package mac_pkg holds:
  - constants W, OW, and the state encoding (ACCUM=1'b0, CAPTURE=1'b1);
  - the quantize function (round/shift/saturate), reusable by other drain variants.
- One sub-module, mac_result_fifo (parameters DEPTH and OW; push/pop/full/empty/head; async active-high rst).

Test Plan:
- cfg_len=4, cfg_shift=0, four beats a=3, b=5 -> product 60 one cycle after beat 4; pe_clear pulses 1 cycle; out_data=60, out_valid=1 on the next cycle.
- cfg_len=1, shift=2, a=61, b=1 -> (61+2)>>2 = 15. Then a=-100, b=1, shift=3 -> (-100+4)>>>3 = -12. sat_flag stays 0.
- cfg_len=1, shift=0, a=b=32767 -> product 1073676289 -> out_data=32767, sat_flag=1 and stays 1 after subsequent small results.
- out_ready=0, cfg_len=2, five windows offered back-to-back:
  - in_ready drops after the 4th capture; 4 entries are held.
  - Raise out_ready: results pop in order, and the 5th window completes only after space frees.
- cfg_len=0 -> behaves as 1: every accepted beat produces one result.
- Gaps: cfg_len=3 with in_valid toggling 1,0,1,0,1 -> a single result equal to the sum of the 3 products.
- Assert rst mid-window (after 2 of 4 beats) with 2 FIFO entries queued:
  - immediately out_valid=0 and pe_clear=1;
  - after release, a fresh 4-beat window yields only its own sum.
